// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned word into the IF/ID pipeline register for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        Clk_40,
    input  logic        Rst_40,
    input  logic        Stall_40,
    input  logic        Flush_40,
    input  logic        BranchTaken_40,
    input  logic [31:0] BranchTarget_40,
    input  logic        Jump_40,
    input  logic [31:0] JumpTarget_40,
    input  logic [31:0] Instruction_40,
    output logic [31:0] Address_40,
    output logic [31:0] IFID_Instruction_40,
    output logic [31:0] IFID_PCPlus4_40,
    output logic        IFID_Valid_40,
    output logic        AddrFault_40,
    output logic        Misalign_40,
    output logic [31:0] FetchCount_40
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        addr_fault_q, addr_fault_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        out_of_range;

    assign pc_plus4        = pc_q + 32'd4;
    assign redirect        = BranchTaken_40 | Jump_40;
    assign redirect_target = BranchTaken_40 ? BranchTarget_40 : JumpTarget_40;
    assign out_of_range    = (pc_q >> 2) >= IMEM_WORDS;

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_plus4_d    = pc_plus4_q;
        valid_d       = valid_q;
        addr_fault_d  = addr_fault_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        // Redirects take priority over a stall so a resolved branch is never lost.
        if (redirect) begin
            pc_d = {redirect_target[31:2], 2'b00};
            if (redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!Stall_40) begin
            pc_d = pc_plus4;
        end

        if (Flush_40 || redirect) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!Stall_40) begin
            if (out_of_range) begin
                instr_d      = NOP_WORD;
                valid_d      = 1'b0;
                addr_fault_d = 1'b1;
            end else begin
                instr_d       = Instruction_40;
                pc_plus4_d    = pc_plus4;
                valid_d       = 1'b1;
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk_40 or negedge Rst_40) begin
        if (!Rst_40) begin
            pc_q          <= RESET_PC;
            instr_q       <= NOP_WORD;
            pc_plus4_q    <= 32'd0;
            valid_q       <= 1'b0;
            addr_fault_q  <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_plus4_q    <= pc_plus4_d;
            valid_q       <= valid_d;
            addr_fault_q  <= addr_fault_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Address_40          = pc_q;
    assign IFID_Instruction_40 = instr_q;
    assign IFID_PCPlus4_40     = pc_plus4_q;
    assign IFID_Valid_40       = valid_q;
    assign AddrFault_40        = addr_fault_q;
    assign Misalign_40         = misalign_q;
    assign FetchCount_40       = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a zero-latency 256-word instruction memory model.
module tb_fetch_stage;

    logic        Clk_40 = 1'b0;
    logic        Rst_40 = 1'b0;
    logic        Stall_40 = 1'b0;
    logic        Flush_40 = 1'b0;
    logic        BranchTaken_40 = 1'b0;
    logic [31:0] BranchTarget_40 = 32'd0;
    logic        Jump_40 = 1'b0;
    logic [31:0] JumpTarget_40 = 32'd0;
    logic [31:0] Instruction_40;
    logic [31:0] Address_40;
    logic [31:0] IFID_Instruction_40;
    logic [31:0] IFID_PCPlus4_40;
    logic        IFID_Valid_40;
    logic        AddrFault_40;
    logic        Misalign_40;
    logic [31:0] FetchCount_40;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] imem [256];

    always #5 Clk_40 = ~Clk_40;

    assign Instruction_40 = (Address_40 < 32'h400) ? imem[Address_40[9:2]] : 32'hBAD0_BAD0;

    fetch_stage dut (
        .Clk_40              (Clk_40),
        .Rst_40              (Rst_40),
        .Stall_40            (Stall_40),
        .Flush_40            (Flush_40),
        .BranchTaken_40      (BranchTaken_40),
        .BranchTarget_40     (BranchTarget_40),
        .Jump_40             (Jump_40),
        .JumpTarget_40       (JumpTarget_40),
        .Instruction_40      (Instruction_40),
        .Address_40          (Address_40),
        .IFID_Instruction_40 (IFID_Instruction_40),
        .IFID_PCPlus4_40     (IFID_PCPlus4_40),
        .IFID_Valid_40       (IFID_Valid_40),
        .AddrFault_40        (AddrFault_40),
        .Misalign_40         (Misalign_40),
        .FetchCount_40       (FetchCount_40)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_40);
        #1;
    endtask

    // Checks address, IF/ID fields and fetch count in one go.
    task automatic expect_state(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                                input logic [31:0] pc4, input logic vld, input logic [31:0] cnt);
        check({tag, ".addr"}, Address_40, addr);
        check({tag, ".ins"}, IFID_Instruction_40, ins);
        check({tag, ".pc4"}, IFID_PCPlus4_40, pc4);
        check({tag, ".vld"}, {31'd0, IFID_Valid_40}, {31'd0, vld});
        check({tag, ".cnt"}, FetchCount_40, cnt);
    endtask

    task automatic expect_reset(input string tag);
        expect_state(tag, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        check({tag, ".fault"}, {31'd0, AddrFault_40}, 32'd0);
        check({tag, ".mis"}, {31'd0, Misalign_40}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'hC0DE_0000 | i;

        // Reset state
        #12;
        expect_reset("rst");
        @(posedge Clk_40);
        #1;
        Rst_40 = 1'b1;

        // Straight-line fetch
        tick(); expect_state("f0", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1, 32'd1);
        tick(); expect_state("f1", 32'h8, 32'hC0DE_0001, 32'h8, 1'b1, 32'd2);

        // Two-cycle stall at PC=8
        Stall_40 = 1'b1;
        tick(); expect_state("st0", 32'h8, 32'hC0DE_0001, 32'h8, 1'b1, 32'd2);
        tick(); expect_state("st1", 32'h8, 32'hC0DE_0001, 32'h8, 1'b1, 32'd2);
        Stall_40 = 1'b0;
        tick(); expect_state("f2", 32'hC, 32'hC0DE_0002, 32'hC, 1'b1, 32'd3);

        // Branch overrides stall
        BranchTaken_40 = 1'b1; BranchTarget_40 = 32'h40; Stall_40 = 1'b1;
        tick(); expect_state("br", 32'h40, 32'h0, 32'hC, 1'b0, 32'd3);
        BranchTaken_40 = 1'b0; Stall_40 = 1'b0;
        tick(); expect_state("br1", 32'h44, 32'hC0DE_0010, 32'h44, 1'b1, 32'd4);

        // Misaligned jump
        Jump_40 = 1'b1; JumpTarget_40 = 32'h23;
        tick(); expect_state("jmp", 32'h20, 32'h0, 32'h44, 1'b0, 32'd4);
        check("jmp.mis", {31'd0, Misalign_40}, 32'd1);
        Jump_40 = 1'b0;
        tick(); expect_state("jmp1", 32'h24, 32'hC0DE_0008, 32'h24, 1'b1, 32'd5);
        check("jmp1.mis", {31'd0, Misalign_40}, 32'd1);

        // Out-of-range fetch
        Jump_40 = 1'b1; JumpTarget_40 = 32'h400;
        tick(); expect_state("oor", 32'h400, 32'h0, 32'h24, 1'b0, 32'd5);
        check("oor.fault0", {31'd0, AddrFault_40}, 32'd0);
        Jump_40 = 1'b0;
        tick();
        check("oor1.ins", IFID_Instruction_40, 32'h0);
        check("oor1.vld", {31'd0, IFID_Valid_40}, 32'd0);
        check("oor1.fault", {31'd0, AddrFault_40}, 32'd1);
        check("oor1.cnt", FetchCount_40, 32'd5);
        check("oor1.addr", Address_40, 32'h404);

        // Back in range; fault stays sticky
        Jump_40 = 1'b1; JumpTarget_40 = 32'h10;
        tick(); check("back.addr", Address_40, 32'h10);
        Jump_40 = 1'b0;
        tick(); expect_state("back1", 32'h14, 32'hC0DE_0004, 32'h14, 1'b1, 32'd6);
        check("back1.fault", {31'd0, AddrFault_40}, 32'd1);

        // Flush together with stall
        Flush_40 = 1'b1; Stall_40 = 1'b1;
        tick(); expect_state("fl", 32'h14, 32'h0, 32'h14, 1'b0, 32'd6);
        Flush_40 = 1'b0; Stall_40 = 1'b0;
        tick(); expect_state("fl1", 32'h18, 32'hC0DE_0005, 32'h18, 1'b1, 32'd7);

        // Branch beats jump
        BranchTaken_40 = 1'b1; BranchTarget_40 = 32'h80; Jump_40 = 1'b1; JumpTarget_40 = 32'h100;
        tick(); expect_state("prio", 32'h80, 32'h0, 32'h18, 1'b0, 32'd7);
        BranchTaken_40 = 1'b0; Jump_40 = 1'b0;
        tick(); expect_state("prio1", 32'h84, 32'hC0DE_0020, 32'h84, 1'b1, 32'd8);

        // Async reset between edges, with a stall pending
        Stall_40 = 1'b1;
        #2;
        Rst_40 = 1'b0;
        #1;
        expect_reset("arst");
        @(posedge Clk_40);
        #1;
        Stall_40 = 1'b0;
        Rst_40 = 1'b1;
        tick(); expect_state("post", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1, 32'd1);
        check("post.mis", {31'd0, Misalign_40}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the 256-word instruction memory. It owns the program counter and drives the memory's byte address. It captures the returned instruction into an IF/ID pipeline register for the decode stage. It handles stall, flush, branch/jump redirect, fetch-range and alignment checks, and keeps a retired-fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
IMEM_WORDS, 256, number of 32-bit words in instruction memory; legal fetch range is PC>>2 < IMEM_WORDS.
NOP_WORD, 32'h0000_0000, instruction inserted on flush or fault.

Ports:
Clk_40  input  1  clock; all state updates on rising edge.
Rst_40  input  1  reset, asynchronous, active-low.
Stall_40  input  1  hazard stall from decode; hold PC and IF/ID.
Flush_40  input  1  squash IF/ID contents next edge.
BranchTaken_40  input  1  branch resolved taken.
BranchTarget_40  input  32  branch target byte address.
Jump_40  input  1  jump request.
JumpTarget_40  input  32  jump target byte address.
Instruction_40  input  32  instruction word returned by instruction memory (combinational read of Address_40).
Address_40  output  32  byte address to instruction memory; equals PC.
IFID_Instruction_40  output  32  registered instruction to decode.
IFID_PCPlus4_40  output  32  registered PC+4 of that instruction.
IFID_Valid_40  output  1  IF/ID holds a real instruction.
AddrFault_40  output  1  sticky: a fetch occurred outside IMEM_WORDS.
Misalign_40  output  1  sticky: a redirect target had nonzero bits [1:0].
FetchCount_40  output  32  count of valid instructions loaded into IF/ID.

Behaviour:
- Reset (Rst_40 low, any time, asynchronous): PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, AddrFault=0, Misalign=0, FetchCount=0. Reset asserted mid-stall or mid-redirect discards all pending state.
- Address_40 = PC combinationally. Instruction_40 is valid in the same cycle (zero-latency memory). Fetch-to-IF/ID latency is 1 cycle.
- PCPlus4 = PC + 4, 32-bit, wraps modulo 2^32.
- Next-PC priority, highest first:
  1. BranchTaken_40 -> {BranchTarget_40[31:2],2'b00}
  2. Jump_40 -> {JumpTarget_40[31:2],2'b00}
  3. Stall_40 -> PC held
  4. else PCPlus4
- A redirect overrides Stall_40.
- Misalign sets when the selected redirect target has bits[1:0] != 0. It stays set until reset.
- IF/ID update priority, highest first:
  1. Flush_40 | BranchTaken_40 | Jump_40 -> Instruction=NOP_WORD, Valid=0, PCPlus4 unchanged.
  2. Stall_40 -> all IF/ID fields held.
  3. else load. If (PC>>2) >= IMEM_WORDS: Instruction=NOP_WORD, Valid=0, AddrFault sets (sticky). Otherwise: Instruction=Instruction_40, PCPlus4=PCPlus4, Valid=1.
- Flush wins over stall when both are asserted in the same cycle.
- FetchCount increments by 1 on every edge where IF/ID loads with Valid=1. It wraps from 32'hFFFF_FFFF to 0. It never increments on stall, flush, redirect or fault cycles.
- No internal state machine beyond the PC and IF/ID registers. Implicit states: RUN (PC advancing), HOLD (stall), REDIRECT (one bubble inserted).
- Outputs change only on clock edges or async reset, except Address_40, which follows the PC register.

Test Plan:
1. Reset release, no stalls, memory words 0..3 = A,B,C,D -> Address_40 sequences 0,4,8,C. IF/ID shows A/PCPlus4=4, then B/8, then C/C, each one cycle after its address. FetchCount reaches 3 after the third load edge.
2. Stall_40 high for 2 cycles while PC=8 -> Address_40 stays 8 and IF/ID holds B/8 for both cycles. On release, C loads next edge and FetchCount does not advance during the stall.
3. BranchTaken_40=1, BranchTarget_40=0x40, with Stall_40=1 at PC=0xC -> next PC=0x40 and IF/ID becomes NOP_WORD, Valid=0. The following edge loads mem[16] with PCPlus4=0x44.
4. Jump_40=1, JumpTarget_40=0x23 -> PC=0x20 and Misalign_40=1. Misalign stays 1 through later normal fetches until Rst_40 pulses low.
5. Jump to 0x400 (word 256) -> IF/ID loads NOP_WORD, Valid=0, AddrFault_40=1 (sticky), FetchCount unchanged. Flush_40 and Stall_40 asserted together on any cycle -> IF/ID becomes NOP, Valid=0.
6. Rst_40 pulled low asynchronously between clock edges mid-run -> all outputs return immediately to reset values and Address_40=RESET_PC.
